// File: rtl/cpu_mem_loader_pkg.sv
// cpu_mem_loader_pkg: shared state encoding and read-mode constants for the memory/loader block
package cpu_mem_loader_pkg;
  typedef enum logic [1:0] {ST_HOLD, ST_LOAD, ST_RUN} state_e;
  localparam int RD_WRITE_FIRST = 0;
  localparam int RD_READ_FIRST = 1;
endpackage

// File: rtl/sp_ram_sync.sv
// sp_ram_sync: synchronous RAM, port A CPU read/write with registered read, port B write-only
module sp_ram_sync
  import cpu_mem_loader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int READ_MODE = RD_WRITE_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (b_we_i) mem[b_addr_i] <= b_wdata_i;
    if (a_we_i) mem[a_addr_i] <= a_wdata_i;
  end
  // a port-B write to the read address is not forwarded: port A sees the old word
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else rdata_q <= (a_we_i && READ_MODE == RD_WRITE_FIRST) ? a_wdata_i : mem[a_addr_i];
  assign a_rdata_o = rdata_q;
endmodule

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: unified CPU memory with a streaming program loader that holds the CPU in reset
module cpu_mem_loader
  import cpu_mem_loader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RST_HOLD = 2,
  parameter int READ_MODE = RD_WRITE_FIRST
) (
  input  logic              clk,
  input  logic              reset,
  output logic              cpu_reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done
);
  localparam int HW = $clog2(RST_HOLD + 1);
  state_e            state_q;
  logic [HW-1:0]     hold_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic              cpu_reset_q, ld_ready_q, ld_done_q;
  logic              ld_acc;
  assign ld_acc = ld_valid && ld_ready_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      cpu_reset_q <= 1'b1;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        ST_LOAD: if (ld_acc) begin
          ptr_q <= ptr_q + ADDR_W'(1);
          rem_q <= rem_q - (ADDR_W + 1)'(1);
          if (rem_q == (ADDR_W + 1)'(1)) begin
            state_q    <= ST_HOLD;
            hold_q     <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b1;
          end
        end
        default: if (ld_start && ld_count != '0) begin
          state_q     <= ST_LOAD;
          ptr_q       <= ld_base;
          rem_q       <= ld_count;
          cpu_reset_q <= 1'b1;
          ld_ready_q  <= 1'b1;
        end else if (ld_start) begin
          state_q     <= ST_HOLD;
          hold_q      <= '0;
          cpu_reset_q <= 1'b1;
          ld_done_q   <= 1'b1;
        end else if (state_q == ST_HOLD) begin
          if (hold_q == HW'(RST_HOLD - 1)) begin
            state_q     <= ST_RUN;
            cpu_reset_q <= 1'b0;
          end else hold_q <= hold_q + HW'(1);
        end
      endcase
    end
  sp_ram_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(READ_MODE)) u_ram (
    .clk      (clk),
    .rst      (reset),
    .a_we_i   (cpu_we && !cpu_reset_q),
    .a_addr_i (cpu_addr),
    .a_wdata_i(cpu_wdata),
    .a_rdata_o(cpu_rdata),
    .b_we_i   (ld_acc),
    .b_addr_i (ptr_q),
    .b_wdata_i(ld_data)
  );
  assign cpu_reset = cpu_reset_q;
  assign ld_ready  = ld_ready_q;
  assign ld_done   = ld_done_q;
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader: self-checking bench for both read modes against a word-array memory model
module tb_cpu_mem_loader;
  localparam int DW = 16, AW = 10, RH = 2, DEPTH = 1024;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_we = 1'b0, ld_start = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0] cpu_addr = '0, ld_base = '0;
  logic [AW:0] ld_count = '0;
  logic [DW-1:0] cpu_wdata = '0, ld_data = '0;
  logic cpu_reset, ld_ready, ld_done, cpu_reset_rf, ld_ready_rf, ld_done_rf;
  logic [DW-1:0] cpu_rdata, rdata_rf;
  logic [DW-1:0] mdl [DEPTH];
  bit init_done = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  cpu_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .RST_HOLD(RH), .READ_MODE(0)) dut (
    .clk(clk), .reset(reset), .cpu_reset(cpu_reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ld_start(ld_start), .ld_base(ld_base),
    .ld_count(ld_count), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done));

  cpu_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .RST_HOLD(RH), .READ_MODE(1)) dut_rf (
    .clk(clk), .reset(reset), .cpu_reset(cpu_reset_rf), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_rf), .ld_start(ld_start), .ld_base(ld_base),
    .ld_count(ld_count), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_rf), .ld_done(ld_done_rf));

  typedef struct {
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, wf, rf;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cpu_we = 0;
    cpu_addr = a;
    tick;
    chk("rd_wf", 32'(cpu_rdata), 32'(mdl[a]));
    chk("rd_rf", 32'(rdata_rf), 32'(mdl[a]));
  endtask

  task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    tick;
    chk("op_wf", 32'(cpu_rdata), we ? 32'(d) : 32'(mdl[a]));
    chk("op_rf", 32'(rdata_rf), 32'(mdl[a]));
    if (we) mdl[a] = d;
    cpu_we = 0;
  endtask

  // CPU keeps trying to write while held in reset; every attempt must be dropped
  task automatic hold_release(input string n);
    logic [AW-1:0] a;
    for (int k = 1; k <= RH; k++) begin
      a = AW'($urandom);
      cpu_we = 1;
      cpu_addr = a;
      cpu_wdata = DW'($urandom);
      tick;
      chk({n, "_cpu_reset"}, 32'(cpu_reset), 32'(k < RH));
      chk({n, "_cpu_reset_rf"}, 32'(cpu_reset_rf), 32'(k < RH));
      chk({n, "_no_done"}, 32'(ld_done), 0);
      if (init_done) begin
        chk({n, "_hold_rd_wf"}, 32'(cpu_rdata), 32'(mdl[a]));
        chk({n, "_hold_rd_rf"}, 32'(rdata_rf), 32'(mdl[a]));
      end
    end
    cpu_we = 0;
  endtask

  // mode 0: valid held high, 1: valid toggles 1,0,1..., 2: random valid plus ignored ld_start pulses
  task automatic do_load(input logic [AW-1:0] base, input logic [AW:0] cnt, input int mode);
    int idx = 0, cyc = 0;
    logic v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cpu_we = 0;
    ld_start = 1;
    ld_base = base;
    ld_count = cnt;
    tick;
    ld_start = 0;
    while (idx < int'(cnt)) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : (cyc > 4 * int'(cnt)) || ($urandom_range(0, 2) != 0);
      a = base + AW'(idx);
      d = DW'($urandom);
      ld_valid = v;
      ld_data = d;
      ld_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      ld_base = AW'($urandom);
      ld_count = (AW + 1)'($urandom_range(1, 9));
      cpu_we = 1;
      cpu_addr = a;
      cpu_wdata = ~d;
      chk("ld_ready", 32'(ld_ready), 1);
      chk("ld_cpu_reset", 32'(cpu_reset), 1);
      chk("ld_done_early", 32'(ld_done), 0);
      tick;
      if (init_done) begin
        chk("ld_rd_wf", 32'(cpu_rdata), 32'(mdl[a]));
        chk("ld_rd_rf", 32'(rdata_rf), 32'(mdl[a]));
      end
      if (v) begin
        mdl[a] = d;
        idx++;
      end
      cyc++;
    end
    ld_valid = 0;
    ld_start = 0;
    cpu_we = 0;
    chk("ld_ready_off", 32'(ld_ready), 0);
    chk("ld_done_pulse", 32'(ld_done), 1);
    chk("ld_done_pulse_rf", 32'(ld_done_rf), 1);
    chk("ld_cpu_reset_end", 32'(cpu_reset), 1);
    hold_release("load");
  endtask

  initial begin
    tbl[0] = '{1'b1, 10'h010, 16'hBEEF, 16'hBEEF, 16'h1111};
    tbl[1] = '{1'b0, 10'h010, 16'h0000, 16'hBEEF, 16'hBEEF};
    tbl[2] = '{1'b0, 10'h011, 16'h0000, 16'h2222, 16'h2222};
    tbl[3] = '{1'b1, 10'h011, 16'hCAFE, 16'hCAFE, 16'h2222};
    tbl[4] = '{1'b1, 10'h011, 16'h0F0F, 16'h0F0F, 16'hCAFE};
    tbl[5] = '{1'b0, 10'h012, 16'h0000, 16'h3333, 16'h3333};
    tbl[6] = '{1'b0, 10'h011, 16'h0000, 16'h0F0F, 16'h0F0F};
    tbl[7] = '{1'b1, 10'h013, 16'h0000, 16'h0000, 16'h4444};
    tbl[8] = '{1'b0, 10'h013, 16'h0000, 16'h0000, 16'h0000};
    tbl[9] = '{1'b0, 10'h010, 16'h0000, 16'hBEEF, 16'hBEEF};

    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_cpu_reset", 32'(cpu_reset), 1);
      chk("rst_rdata", 32'(cpu_rdata), 0);
      chk("rst_rdata_rf", 32'(rdata_rf), 0);
      chk("rst_ready", 32'(ld_ready), 0);
      chk("rst_done", 32'(ld_done), 0);
    end
    reset = 0;
    hold_release("rel");

    do_load('0, 11'(DEPTH), 0);
    init_done = 1;
    for (int i = 0; i < 8; i++) rd(AW'($urandom));

    do_load(10'h000, 11'd5, 0);
    for (int i = 0; i < 6; i++) rd(AW'(i));

    do_load(10'h020, 11'd3, 1);
    for (int i = 0; i < 5; i++) rd(10'h01F + AW'(i));

    do_load(10'h3FE, 11'd4, 0);
    for (int i = 0; i < 6; i++) rd(10'h3FD + AW'(i));

    cpu_op(1'b1, 10'h010, 16'h1111);
    cpu_op(1'b1, 10'h011, 16'h2222);
    cpu_op(1'b1, 10'h012, 16'h3333);
    cpu_op(1'b1, 10'h013, 16'h4444);
    for (int i = 0; i < 10; i++) begin
      cpu_we = tbl[i].we;
      cpu_addr = tbl[i].a;
      cpu_wdata = tbl[i].d;
      tick;
      chk($sformatf("tbl%0d_wf", i), 32'(cpu_rdata), 32'(tbl[i].wf));
      chk($sformatf("tbl%0d_rf", i), 32'(rdata_rf), 32'(tbl[i].rf));
      if (tbl[i].we) mdl[tbl[i].a] = tbl[i].d;
    end
    cpu_we = 0;

    ld_start = 1;
    ld_count = '0;
    ld_base = 10'h155;
    tick;
    ld_start = 0;
    chk("zero_done", 32'(ld_done), 1);
    chk("zero_ready", 32'(ld_ready), 0);
    chk("zero_cpu_reset", 32'(cpu_reset), 1);
    hold_release("zero");
    rd(10'h155);

    ld_start = 1;
    ld_base = 10'h100;
    ld_count = 11'd6;
    tick;
    ld_start = 0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1;
      ld_data = DW'($urandom);
      tick;
      mdl[10'h100 + AW'(i)] = ld_data;
    end
    ld_data = DW'($urandom);
    #2;
    reset = 1;
    #1;
    ld_valid = 0;
    chk("abort_ready", 32'(ld_ready), 0);
    chk("abort_cpu_reset", 32'(cpu_reset), 1);
    chk("abort_done", 32'(ld_done), 0);
    chk("abort_rdata", 32'(cpu_rdata), 0);
    tick;
    chk("abort_done2", 32'(ld_done), 0);
    reset = 0;
    hold_release("abort");
    for (int i = 0; i < 7; i++) rd(10'h100 + AW'(i));

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 60; i++) cpu_op(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      chk("run_cpu_reset", 32'(cpu_reset), 0);
      do_load(AW'($urandom), (AW + 1)'($urandom_range(1, 40)), 2);
    end
    for (int i = 0; i < 60; i++) cpu_op(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
